// File: rtl/piggy_pkg.sv
// Shared types and constants for the piggy-bank UART command receiver.
// Holds the receiver state encoding and the ASCII command bytes it decodes.
package piggy_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } rx_state_t;

    localparam logic [7:0] CMD_REPORT_U = 8'h53;  // 'S'
    localparam logic [7:0] CMD_REPORT_L = 8'h73;  // 's'
    localparam logic [7:0] CMD_CLEAR_U  = 8'h43;  // 'C'
    localparam logic [7:0] CMD_CLEAR_L  = 8'h63;  // 'c'

    function automatic logic is_report(input logic [7:0] b);
        return (b == CMD_REPORT_U) || (b == CMD_REPORT_L);
    endfunction

    function automatic logic is_clear(input logic [7:0] b);
        return (b == CMD_CLEAR_U) || (b == CMD_CLEAR_L);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: two-flop synchronizer, mid-bit sampling FSM,
// good-byte strobe and stop-bit framing error strobe.
module uart_rx
    import piggy_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic       rx_active,
    output logic       rx_dv,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output rx_state_t  state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] BIT_CNT  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta;
    logic             rx_s;
    rx_state_t        next_state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!rx_s) next_state = START;
            START:   if (cnt == HALF_CNT) next_state = rx_s ? IDLE : DATA;
            DATA:    if (cnt == BIT_CNT && bit_idx == 3'd7) next_state = STOP;
            STOP:    if (cnt == BIT_CNT) next_state = CLEANUP;
            CLEANUP: if (rx_s) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        rx_active = (state == START) || (state == DATA) || (state == STOP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_byte   <= 8'h00;
            rx_dv     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_dv     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                end
                START: cnt <= (cnt == HALF_CNT) ? '0 : cnt + CNT_W'(1);
                DATA: begin
                    if (cnt == BIT_CNT) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    // rx_byte only moves on a good stop bit; a bad one leaves the last good byte.
                    if (cnt == BIT_CNT) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rx_dv   <= 1'b1;
                            rx_byte <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CLEANUP: cnt <= '0;
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cmd.sv
// UART receiver plus registered command decoder: 'S'/'s' requests a balance
// report, 'C'/'c' clears the coin counters, one cycle after the byte strobe.
module uart_rx_cmd
    import piggy_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_Active,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_frame_err,
    output logic       o_cmd_report,
    output logic       o_cmd_clear
);

    rx_state_t rx_state;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (i_Rx_Serial),
        .rx_active (o_Rx_Active),
        .rx_dv     (o_Rx_DV),
        .rx_byte   (o_Rx_Byte),
        .frame_err (o_frame_err),
        .state     (rx_state)
    );

    // Decoding only on the good-byte strobe keeps framing errors command-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_cmd_report <= 1'b0;
            o_cmd_clear  <= 1'b0;
        end else begin
            o_cmd_report <= o_Rx_DV && is_report(o_Rx_Byte);
            o_cmd_clear  <= o_Rx_DV && is_clear(o_Rx_Byte);
        end
    end

    always_comb begin
        if (!rst && o_Rx_DV) assert (rx_state == CLEANUP);
    end

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Bench for uart_rx_cmd at 16 clocks per bit: frame-level timing model,
// per-cycle output compare, byte scoreboard and directed literal checks.
module tb_uart_rx_cmd;

    localparam int CPB    = 16;
    localparam int HALF   = (CPB - 1) / 2;
    // Cycles from the first start-bit sample to the byte strobe:
    // mid-start sample at HALF+1, nine more bit periods, two cycles of FSM/output registering.
    localparam int DV_LAT = HALF + 3 + 9 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_q = 1'b1;
    logic       rx_line = 1'b1;
    logic       rx_active, rx_dv, frame_err, cmd_report, cmd_clear;
    logic [7:0] rx_byte;

    uart_rx_cmd #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_Rx_Serial  (rx_line),
        .o_Rx_Active  (rx_active),
        .o_Rx_DV      (rx_dv),
        .o_Rx_Byte    (rx_byte),
        .o_frame_err  (frame_err),
        .o_cmd_report (cmd_report),
        .o_cmd_clear  (cmd_clear)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // ---------------- model state ----------------
    typedef struct { int t; bit good; logic [7:0] b; } ev_t;
    typedef struct { int s; int e; } win_t;

    ev_t        ev_q[$];
    win_t       win_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] model_byte = 8'h00;

    int errors = 0;
    int checks = 0;

    // monitor counters used by the directed literal checks
    int         dv_cnt = 0, err_cnt = 0, rep_cnt = 0, clr_cnt = 0;
    int         last_dv_cyc = 0, last_rep_cyc = 0, last_clr_cyc = 0, last_act_cyc = 0;
    logic [7:0] dv_log[$];

    function automatic bit is_rep(input logic [7:0] b);
        return (b == 8'h53) || (b == 8'h73);
    endfunction

    function automatic bit is_clr(input logic [7:0] b);
        return (b == 8'h43) || (b == 8'h63);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    bit         e_dv, e_err, e_rep, e_clr, e_act;
    int         n;
    logic [7:0] sb_byte;

    always @(negedge clk) begin
        n     = cyc;
        e_dv  = 1'b0;
        e_err = 1'b0;
        e_rep = 1'b0;
        e_clr = 1'b0;
        e_act = 1'b0;
        if (rst_q) begin
            model_byte = 8'h00;
            exp_q.delete();
            for (int i = ev_q.size() - 1; i >= 0; i--)
                if (ev_q[i].t >= n) ev_q.delete(i);
            foreach (win_q[i])
                if (win_q[i].e >= n) win_q[i].e = n - 1;
        end else begin
            foreach (ev_q[i]) begin
                if (ev_q[i].t == n) begin
                    if (ev_q[i].good) begin
                        e_dv       = 1'b1;
                        model_byte = ev_q[i].b;
                    end else begin
                        e_err = 1'b1;
                    end
                end
                if (ev_q[i].t == n - 1 && ev_q[i].good) begin
                    e_rep = is_rep(ev_q[i].b);
                    e_clr = is_clr(ev_q[i].b);
                end
            end
            foreach (win_q[i])
                if (win_q[i].s <= n && n <= win_q[i].e) e_act = 1'b1;
        end

        chk("rx_dv", rx_dv, e_dv);
        chk("frame_err", frame_err, e_err);
        chk("cmd_report", cmd_report, e_rep);
        chk("cmd_clear", cmd_clear, e_clr);
        chk("rx_active", rx_active, e_act);
        chk("rx_byte", rx_byte, model_byte);

        if (rx_dv === 1'b1 && !rst_q) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_dv", 1, 0);
            end else begin
                sb_byte = exp_q.pop_front();
                chk("sb_byte", rx_byte, sb_byte);
            end
        end

        if (rx_dv === 1'b1)      begin dv_cnt++; last_dv_cyc = n; dv_log.push_back(rx_byte); end
        if (frame_err === 1'b1)  err_cnt++;
        if (cmd_report === 1'b1) begin rep_cnt++; last_rep_cyc = n; end
        if (cmd_clear === 1'b1)  begin clr_cnt++; last_clr_cyc = n; end
        if (rx_active === 1'b1)  last_act_cyc = n;

        for (int i = ev_q.size() - 1; i >= 0; i--)
            if (ev_q[i].t < n - 1) ev_q.delete(i);
        for (int i = win_q.size() - 1; i >= 0; i--)
            if (win_q[i].e < n) win_q.delete(i);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int low_hold,
                              output int p);
        p = cyc + 1;
        rx_line = 1'b0;
        ev_q.push_back('{t: p + DV_LAT, good: stop_ok, b: b});
        win_q.push_back('{s: p + 2, e: p + DV_LAT - 1});
        if (stop_ok) exp_q.push_back(b);
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            tick(CPB);
        end
        rx_line = stop_ok;
        tick(CPB);
        if (!stop_ok) begin
            tick(low_hold);
            rx_line = 1'b1;
            tick(4);
        end
    endtask

    task automatic glitch(input int len, output int p);
        p = cyc + 1;
        rx_line = 1'b0;
        win_q.push_back('{s: p + 2, e: p + 2 + HALF});
        tick(len);
        rx_line = 1'b1;
        tick(20 - len);
    endtask

    // Starts a frame and pulses reset partway through bit 4.
    task automatic send_with_reset(input logic [7:0] b);
        int p;
        p = cyc + 1;
        rx_line = 1'b0;
        ev_q.push_back('{t: p + DV_LAT, good: 1'b1, b: b});
        win_q.push_back('{s: p + 2, e: p + DV_LAT - 1});
        exp_q.push_back(b);
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_line = b[i];
            tick(CPB);
        end
        rx_line = b[4];
        tick(CPB / 2);
        rst = 1'b1;
        tick(3);
        rx_line = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
    endtask

    // ---------------- stimulus ----------------
    int         p, s_dv, s_err, s_rep, s_clr, kind;
    logic [7:0] rb;
    logic [7:0] cmd_bytes [4] = '{8'h53, 8'h73, 8'h43, 8'h63};

    initial begin
        rst = 1'b1;
        rx_line = 1'b1;
        tick(3);
        chk("reset_active", rx_active, 0);
        chk("reset_dv", rx_dv, 0);
        chk("reset_byte", rx_byte, 8'h00);
        chk("reset_cmds", {cmd_report, cmd_clear, frame_err}, 3'b000);
        rst = 1'b0;
        tick(5);

        // 'S' -> byte strobe, report exactly one cycle later, no clear
        s_dv = dv_cnt; s_rep = rep_cnt; s_clr = clr_cnt;
        send_frame(8'h53, 1'b1, 0, p);
        tick(5);
        chk("s_dv_count", dv_cnt - s_dv, 1);
        chk("s_dv_latency", last_dv_cyc - p, 154);
        chk("s_dv_byte", dv_log[dv_log.size() - 1], 8'h53);
        chk("s_report_count", rep_cnt - s_rep, 1);
        chk("s_report_delay", last_rep_cyc - last_dv_cyc, 1);
        chk("s_clear_count", clr_cnt - s_clr, 0);

        // 'c' then 'A' back to back
        s_dv = dv_cnt; s_rep = rep_cnt; s_clr = clr_cnt;
        send_frame(8'h63, 1'b1, 0, p);
        send_frame(8'h41, 1'b1, 0, p);
        tick(5);
        chk("cA_dv_count", dv_cnt - s_dv, 2);
        chk("cA_clear_count", clr_cnt - s_clr, 1);
        chk("cA_report_count", rep_cnt - s_rep, 0);
        chk("cA_final_byte", rx_byte, 8'h41);

        // 5-cycle glitch on idle line
        s_dv = dv_cnt; s_err = err_cnt;
        glitch(5, p);
        chk("glitch_dv", dv_cnt - s_dv, 0);
        chk("glitch_err", err_cnt - s_err, 0);
        chk("glitch_active_end", last_act_cyc - p, 9);

        // 'S' with a low stop bit and the line held low for 40 more cycles
        s_dv = dv_cnt; s_err = err_cnt; s_rep = rep_cnt;
        send_frame(8'h53, 1'b0, 40, p);
        chk("ferr_count", err_cnt - s_err, 1);
        chk("ferr_dv", dv_cnt - s_dv, 0);
        chk("ferr_report", rep_cnt - s_rep, 0);
        chk("ferr_byte_kept", rx_byte, 8'h41);
        chk("ferr_no_restart", last_act_cyc - p, 153);

        // reset in the middle of 'C', then a clean 'C'
        s_dv = dv_cnt; s_err = err_cnt; s_clr = clr_cnt;
        send_with_reset(8'h43);
        tick(200);
        chk("rst_dv", dv_cnt - s_dv, 0);
        chk("rst_err", err_cnt - s_err, 0);
        chk("rst_clear", clr_cnt - s_clr, 0);
        chk("rst_byte", rx_byte, 8'h00);
        send_frame(8'h43, 1'b1, 0, p);
        tick(5);
        chk("post_rst_clear", clr_cnt - s_clr, 1);
        chk("post_rst_clear_delay", last_clr_cyc - last_dv_cyc, 1);

        // bit-order patterns
        send_frame(8'hFF, 1'b1, 0, p);
        send_frame(8'h00, 1'b1, 0, p);
        send_frame(8'h01, 1'b1, 0, p);
        tick(5);
        chk("order_ff", dv_log[dv_log.size() - 3], 8'hFF);
        chk("order_00", dv_log[dv_log.size() - 2], 8'h00);
        chk("order_lsb_first", dv_log[dv_log.size() - 1], 8'h01);

        // randomized traffic
        for (int k = 0; k < 25; k++) begin
            kind = $urandom_range(0, 9);
            rb = ($urandom_range(0, 3) == 0) ? cmd_bytes[$urandom_range(0, 3)]
                                             : 8'($urandom_range(0, 255));
            if (kind == 0)
                glitch($urandom_range(1, 6), p);
            else if (kind == 1)
                send_frame(rb, 1'b0, $urandom_range(0, 30), p);
            else
                send_frame(rb, 1'b1, 0, p);
            tick($urandom_range(0, 15));
        end

        tick(20);
        chk("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
